// File: rtl/risc_fetch_stage.sv
// RiSC instruction-fetch stage: sync imem read port, credit-counted prefetch FIFO, valid/ready to decode.
// Optional HALT detection (fetch stops after an opcode-7 instruction) is enabled by FETCH_HALT_DETECT_EN.
module risc_fetch_stage #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              id_ready,
    output logic              fetch_halted
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_run;
    logic              r_outstanding;
    logic              r_halted;
    logic [DATA_W-1:0] r_mem_inst [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_mem_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_last_inst;
    logic [ADDR_W-1:0] r_last_pc;

    logic              w_pop;
    logic              w_push;
    logic              w_halt_hit;
    logic [CNT_W:0]    w_used;

    assign id_valid = (r_count != '0);
    assign id_inst  = id_valid ? r_mem_inst[r_rd_ptr] : r_last_inst;
    assign id_pc    = id_valid ? r_mem_pc[r_rd_ptr]   : r_last_pc;

    assign w_pop  = id_valid && id_ready;
    assign w_push = r_outstanding;

    // Credits: an entry leaving this cycle frees a slot for a request issued this cycle.
    assign w_used = {1'b0, r_count} + (CNT_W+1)'(r_outstanding) - (CNT_W+1)'(w_pop);

    assign imem_req  = r_run && !r_halted && !redirect_valid && (w_used < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_addr = r_fetch_pc;

`ifdef FETCH_HALT_DETECT_EN
    assign w_halt_hit = w_push && (imem_rdata[7:4] == 4'd7);
`else
    assign w_halt_hit = 1'b0;
`endif

    assign fetch_halted = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_halted      <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc    <= redirect_pc;
                r_outstanding <= 1'b0;
                r_halted      <= 1'b0;
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_count       <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                if (w_halt_hit) r_halted <= 1'b1;
                // The fetch issued alongside a HALT write is for the next PC and must be dropped.
                r_outstanding <= imem_req && !w_halt_hit;
                if (imem_req) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                    r_req_pc   <= r_fetch_pc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (w_push && !redirect_valid) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    // Last transferred head is kept so the decode outputs hold while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_inst <= '0;
            r_last_pc   <= '0;
        end else if (w_pop) begin
            r_last_inst <= r_mem_inst[r_rd_ptr];
            r_last_pc   <= r_mem_pc[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_risc_fetch_stage.sv
// Directed bench for risc_fetch_stage: sync memory model, transfer log, hand-computed expectations.
module tb_risc_fetch_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata = 8'h00;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       id_valid;
    logic [7:0] id_inst;
    logic [7:0] id_pc;
    logic       id_ready = 1'b0;
    logic       fetch_halted;

    logic [7:0]  mem [256];
    logic [15:0] q [$];
    int n_cmp = 0;
    int n_err = 0;

    risc_fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready),
        .fetch_halted(fetch_halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

    always @(negedge clk) if (rst_n && id_valid && id_ready) q.push_back({id_pc, id_inst});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        id_ready = ready;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h10 | 8'(i & 15);
        mem[8'h00] = 8'hbf; mem[8'h01] = 8'hf0; mem[8'h02] = 8'h90; mem[8'h03] = 8'hd0;
        mem[8'hFE] = 8'h06; mem[8'hFF] = 8'h00; mem[8'h05] = 8'h70;

        // Test 1: reset values, latency, back-to-back delivery
        id_ready = 1'b1;
        #12;
        chk("rst_valid", id_valid, 0);
        chk("rst_inst", id_inst, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_halt", fetch_halted, 0);
        do_reset(1'b1);
        tick();
        chk("t1_req0", imem_req, 1);
        chk("t1_addr0", imem_addr, 8'h00);
        tick();
        chk("t1_valid_lat", id_valid, 0);
        chk("t1_addr1", imem_addr, 8'h01);
        tick(); chk("t1_d0", {id_valid, id_pc, id_inst}, {1'b1, 8'h00, 8'hbf});
        tick(); chk("t1_d1", {id_valid, id_pc, id_inst}, {1'b1, 8'h01, 8'hf0});
        tick(); chk("t1_d2", {id_valid, id_pc, id_inst}, {1'b1, 8'h02, 8'h90});
        tick(); chk("t1_d3", {id_valid, id_pc, id_inst}, {1'b1, 8'h03, 8'hd0});

        // Test 2: backpressure holds head, fetch stops when full, no loss on release
        do_reset(1'b0);
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold", {id_valid, id_pc, id_inst}, {1'b1, 8'h00, 8'hbf});
            chk("t2_noreq", imem_req, 0);
            tick();
        end
        q.delete();
        id_ready = 1'b1;
        repeat (6) tick();
        chk("t2_n", q.size() >= 4, 1);
        chk("t2_q0", q[0], {8'h00, 8'hbf});
        chk("t2_q1", q[1], {8'h01, 8'hf0});
        chk("t2_q2", q[2], {8'h02, 8'h90});
        chk("t2_q3", q[3], {8'h03, 8'hd0});

        // Test 3: redirect with a response in flight discards stale fetches
        do_reset(1'b1);
        tick(); tick(); tick();
        tick();
        chk("t3_pre", id_pc, 8'h01);
        redirect_valid = 1'b1;
        redirect_pc = 8'h20;
        #1 chk("t3_req_redir", imem_req, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t3_req_tgt", {imem_req, imem_addr}, {1'b1, 8'h20});
        repeat (6) tick();
        chk("t3_n", q.size() >= 5, 1);
        chk("t3_q1", q[1], {8'h01, 8'hf0});
        chk("t3_q2", q[2], {8'h20, 8'h10});
        chk("t3_q3", q[3], {8'h21, 8'h11});
        chk("t3_q4", q[4], {8'h22, 8'h12});

        // Test 4: redirect near top of address space wraps FF -> 00
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        q.delete();
        repeat (6) tick();
        chk("t4_q0", q[0], {8'hFE, 8'h06});
        chk("t4_q1", q[1], {8'hFF, 8'h00});
        chk("t4_q2", q[2], {8'h00, 8'hbf});

        // Test 5: HALT handling
        do_reset(1'b1);
        repeat (12) tick();
`ifdef FETCH_HALT_DETECT_EN
        chk("t5_n", q.size(), 6);
        chk("t5_halt_inst", q[5], {8'h05, 8'h70});
        chk("t5_halted", fetch_halted, 1);
        chk("t5_noreq", imem_req, 0);
        chk("t5_empty", id_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        tick();
        redirect_valid = 1'b0;
        chk("t5_unhalt", fetch_halted, 0);
        q.delete();
        repeat (5) tick();
        chk("t5_resume", q[0], {8'h00, 8'hbf});
`else
        chk("t5_nohalt", fetch_halted, 0);
        chk("t5_past", q[5], {8'h05, 8'h70});
        chk("t5_next", q[6], {8'h06, 8'h16});
`endif

        // Test 6: asynchronous reset mid-stream
        do_reset(1'b1);
        repeat (5) tick();
        chk("t6_pre", id_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_valid_async", id_valid, 0);
        chk("t6_req_async", imem_req, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        q.delete();
        repeat (6) tick();
        chk("t6_first", q[0], {8'h00, 8'hbf});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
